// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 64;
    localparam int HALF_SEL_BIT = 2;

    localparam logic SIZE_32 = 1'b0;
    localparam logic SIZE_64 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Insert a 32-bit word into the doubleword half chosen by 'half'.
    function automatic logic [63:0] merge_word(input logic [63:0] dword,
                                               input logic [31:0] word,
                                               input logic        half);
        logic [63:0] res;
        res = dword;
        if (half) begin
            res[63:32] = word;
        end else begin
            res[31:0] = word;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Phase timer: loadable down-counter. A start pulse loads WAIT_CYCLES;
// phase_done is high in the last cycle of the phase, i.e. after
// WAIT_CYCLES+1 cycles. A new start reloads it even while active.
module mem_wait_timer #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic phase_done
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    // Next-count: reload on start, count down while active, stop at zero.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            cnt_d    = LOAD_VAL;
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign phase_done = active_q && (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns single load/store requests into
// cs/oe/we phases on a 64-bit memory port. 32-bit stores are done as
// read-modify-write. Optional alignment checking is enabled by defining
// MEM_CTRL_ALIGN_CHECK_EN; without it error is tied low and the low
// address bits are ignored.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for a request
// ST_READ  | cs+oe held for WAIT_CYCLES+1 cycles, data sampled at end
// ST_WRITE | cs+we held for WAIT_CYCLES+1 cycles, wdata stable
// ST_RESP  | one-cycle valid pulse, no acceptance this cycle
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              valid,
    output logic              error,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              size_q, size_d;
    logic              we_q, we_d;
    logic              half_q, half_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              mem_cs_q, mem_cs_d;
    logic              mem_oe_q, mem_oe_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [31:0]       sel_word;
    logic              misaligned;
    logic              phase_start;
    logic              phase_done;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    logic error_q, error_d;

    assign misaligned = (req_size == SIZE_32) ? (req_addr[1:0] != 2'b00)
                                              : (req_addr[2:0] != 3'b000);
    assign error      = error_q;
`else
    logic unused_addr_lo;

    assign misaligned     = 1'b0;
    assign unused_addr_lo = ^req_addr[1:0];
    assign error          = 1'b0;
`endif

    assign sel_word = half_q ? mem_rdata[63:32] : mem_rdata[31:0];

    mem_wait_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (phase_start),
        .phase_done (phase_done)
    );

    // Next-state, datapath and output decode; outputs follow state_d so
    // they are registered together with the state.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        we_d        = we_q;
        half_d      = half_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        phase_start = 1'b0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        error_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d = req_size;
                    we_d   = req_we;
                    half_d = req_addr[HALF_SEL_BIT];
                    if (misaligned) begin
                        state_d = ST_RESP;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
                        error_d = 1'b1;
`endif
                    end else begin
                        mem_addr_d  = {3'b000, req_addr[ADDR_W-1:3]};
                        mem_wdata_d = req_wdata;
                        phase_start = 1'b1;
                        if (req_we && (req_size == SIZE_64)) begin
                            state_d = ST_WRITE;
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                if (phase_done) begin
                    if (!we_q) begin
                        state_d = ST_RESP;
                        if (size_q == SIZE_64) begin
                            rdata_d = mem_rdata;
                        end else begin
                            rdata_d = {{(DATA_W-32){1'b0}}, sel_word};
                        end
                    end else begin
                        // Only 32-bit stores read first: splice in the new word.
                        state_d     = ST_WRITE;
                        phase_start = 1'b1;
                        mem_wdata_d = merge_word(mem_rdata, mem_wdata_q[31:0], half_q);
                    end
                end
            end
            ST_WRITE: begin
                if (phase_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d   = (state_d == ST_READ) || (state_d == ST_WRITE);
        mem_cs_d = busy_d;
        mem_oe_d = (state_d == ST_READ);
        mem_we_d = (state_d == ST_WRITE);
        valid_d  = (state_d == ST_RESP);
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            size_q      <= SIZE_32;
            we_q        <= 1'b0;
            half_q      <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            we_q        <= we_d;
            half_q      <= half_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            mem_cs_q    <= mem_cs_d;
            mem_oe_q    <= mem_oe_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
            error_q     <= error_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign rdata     = rdata_q;
    assign mem_cs    = mem_cs_q;
    assign mem_oe    = mem_oe_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a small behavioural memory.
module tb_mem_access_ctrl;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        req_size = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        busy, valid, error;
    logic [63:0] rdata;
    logic        mem_cs, mem_oe, mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (64),
        .WAIT_CYCLES (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .valid     (valid),
        .error     (error),
        .rdata     (rdata),
        .mem_cs    (mem_cs),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural memory, 32 doublewords.
    logic [63:0] mem [0:31] = '{default: 64'h0};

    always @(posedge clk) begin
        if (mem_cs && mem_we) mem[mem_addr[4:0]] <= mem_wdata;
    end

    always_comb begin
        mem_rdata = (mem_cs && mem_oe) ? mem[mem_addr[4:0]] : 64'h0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          acc;
        int          lat;
        logic        err;
        logic [63:0] rd;
        bit          chk_idx;
        logic [31:0] idx;
        int          cs_n;
        int          we_n;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   overlap = 0;
    int   wd_unstable = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every valid pulse.
    initial begin : monitor
        exp_t        e;
        int          cs_cnt;
        int          we_cnt;
        logic        prev_we;
        logic [63:0] prev_wd;
        cs_cnt  = 0;
        we_cnt  = 0;
        prev_we = 1'b0;
        prev_wd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cs_cnt  = 0;
                we_cnt  = 0;
                prev_we = 1'b0;
            end else begin
                if (mem_cs) cs_cnt++;
                if (mem_we) we_cnt++;
                if (mem_oe && mem_we) overlap++;
                if (mem_we && prev_we && (mem_wdata !== prev_wd)) wd_unstable++;
                prev_we = mem_we;
                prev_wd = mem_wdata;
                if (valid) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_valid actual=1 required=0 at cycle %0d", cyc);
                    end else begin
                        e = sbq.pop_front();
                        check({e.name, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
                        check({e.name, "_error"},   64'(error), 64'(e.err));
                        check({e.name, "_rdata"},   rdata, e.rd);
                        check({e.name, "_cs_cycles"}, 64'(cs_cnt), 64'(e.cs_n));
                        check({e.name, "_we_cycles"}, 64'(we_cnt), 64'(e.we_n));
                        if (e.chk_idx) check({e.name, "_mem_addr"}, 64'(mem_addr), 64'(e.idx));
                    end
                    cs_cnt = 0;
                    we_cnt = 0;
                end
            end
        end
    end

    // Present a request, hold it until the DUT accepts, push the expectation.
    task automatic issue(input string name, input logic we, input logic sz,
                         input logic [31:0] addr, input logic [63:0] wd,
                         input int lat, input logic err, input logic [63:0] rd,
                         input bit chk_idx, input logic [31:0] idx,
                         input int cs_n, input int we_n, output int acc);
        exp_t e;
        bit   got;
        int   n;
        got       = 1'b0;
        n         = 0;
        req_we    = we;
        req_size  = sz;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        while (!got && n < 40) begin
            @(negedge clk);
            got = !busy && !valid;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        acc       = cyc;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_accept actual=timeout required=accepted", name);
        end else begin
            e.name    = name;
            e.acc     = cyc;
            e.lat     = lat;
            e.err     = err;
            e.rd      = rd;
            e.chk_idx = chk_idx;
            e.idx     = idx;
            e.cs_n    = cs_n;
            e.we_n    = we_n;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((sbq.size() != 0 || busy || valid) && n < 60);
        if (n >= 60) begin
            total++;
            bad++;
            $display("FAIL %s_drain actual=timeout required=idle", name);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a1, a2, a3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_mem_cs", 64'(mem_cs), 64'd0);
        check("rst_mem_oe", 64'(mem_oe), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a write phase.
        issue("st64_abort", 1'b1, 1'b1, 32'h80, 64'h1111_1111_1111_1111,
              3, 1'b0, 64'h0, 1'b1, 32'h10, 2, 2, a1);
        for (int n = 0; n < 10 && !mem_we; n++) @(negedge clk);
        check("abort_in_write", 64'(mem_we), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_mem_cs", 64'(mem_cs), 64'd0);
        check("abort_mem_oe", 64'(mem_oe), 64'd0);
        check("abort_mem_we", 64'(mem_we), 64'd0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 64-bit round trip.
        issue("st64", 1'b1, 1'b1, 32'h40, 64'h0123_4567_89AB_CDEF,
              W + 2, 1'b0, 64'h0, 1'b1, 32'h8, W + 1, W + 1, a1);
        wait_idle("st64");
        issue("ld64", 1'b0, 1'b1, 32'h40, 64'h0,
              W + 2, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 32'h8, W + 1, 0, a1);
        wait_idle("ld64");

        // 32-bit store into the upper half, upper req_wdata bits must be ignored.
        issue("st32_hi", 1'b1, 1'b0, 32'h44, 64'hFFFF_FFFF_DEAD_BEEF,
              2 * W + 3, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 32'h8,
              2 * (W + 1), W + 1, a1);
        wait_idle("st32_hi");
        check("mem_after_st32_hi", mem[8], 64'hDEAD_BEEF_89AB_CDEF);

        // 32-bit loads of each half.
        issue("ld32_lo", 1'b0, 1'b0, 32'h40, 64'h0,
              W + 2, 1'b0, 64'h0000_0000_89AB_CDEF, 1'b1, 32'h8, W + 1, 0, a1);
        issue("ld32_hi", 1'b0, 1'b0, 32'h44, 64'h0,
              W + 2, 1'b0, 64'h0000_0000_DEAD_BEEF, 1'b1, 32'h8, W + 1, 0, a1);
        wait_idle("ld32");

        // 32-bit store into the lower half.
        issue("st32_lo", 1'b1, 1'b0, 32'h40, 64'h0000_0000_5566_7788,
              2 * W + 3, 1'b0, 64'h0000_0000_DEAD_BEEF, 1'b1, 32'h8,
              2 * (W + 1), W + 1, a1);
        wait_idle("st32_lo");
        check("mem_after_st32_lo", mem[8], 64'hDEAD_BEEF_5566_7788);

        // Back-to-back with req_valid held: second accepted in IDLE after RESP.
        issue("b2b_1", 1'b0, 1'b1, 32'h40, 64'h0,
              W + 2, 1'b0, 64'hDEAD_BEEF_5566_7788, 1'b1, 32'h8, W + 1, 0, a1);
        issue("b2b_2", 1'b0, 1'b0, 32'h44, 64'h0,
              W + 2, 1'b0, 64'h0000_0000_DEAD_BEEF, 1'b1, 32'h8, W + 1, 0, a2);
        check("b2b_accept_gap", 64'(a2 - a1), 64'(W + 3));
        wait_idle("b2b");

        // A request pulsed only while busy is dropped.
        issue("drop_host", 1'b0, 1'b1, 32'h40, 64'h0,
              W + 2, 1'b0, 64'hDEAD_BEEF_5566_7788, 1'b1, 32'h8, W + 1, 0, a3);
        @(negedge clk);
        check("drop_busy", 64'(busy), 64'd1);
        req_we    = 1'b1;
        req_size  = 1'b1;
        req_addr  = 32'h48;
        req_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_idle("drop");
        repeat (3) @(posedge clk);
        #1;
        check("drop_mem_untouched", mem[9], 64'h0);

        // Misaligned requests.
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        issue("mis64", 1'b0, 1'b1, 32'h44, 64'h0,
              1, 1'b1, 64'hDEAD_BEEF_5566_7788, 1'b0, 32'h0, 0, 0, a1);
        wait_idle("mis64");
        issue("mis32", 1'b0, 1'b0, 32'h41, 64'h0,
              1, 1'b1, 64'hDEAD_BEEF_5566_7788, 1'b0, 32'h0, 0, 0, a1);
        wait_idle("mis32");
        issue("mis_st64", 1'b1, 1'b1, 32'h43, 64'h5A5A_5A5A_5A5A_5A5A,
              1, 1'b1, 64'hDEAD_BEEF_5566_7788, 1'b0, 32'h0, 0, 0, a1);
        wait_idle("mis_st64");
        check("mis_mem_untouched", mem[8], 64'hDEAD_BEEF_5566_7788);
`else
        issue("mis64", 1'b0, 1'b1, 32'h44, 64'h0,
              W + 2, 1'b0, 64'hDEAD_BEEF_5566_7788, 1'b1, 32'h8, W + 1, 0, a1);
        wait_idle("mis64");
        issue("mis32", 1'b0, 1'b0, 32'h41, 64'h0,
              W + 2, 1'b0, 64'h0000_0000_5566_7788, 1'b1, 32'h8, W + 1, 0, a1);
        wait_idle("mis32");
`endif

        check("oe_we_overlap", 64'(overlap), 64'd0);
        check("wdata_stable_in_write", 64'(wd_unstable), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
